// File: rtl/mag_power_ctrl.sv
// Magnetron power-level sequencer. Drives the set/reset inputs of the
// downstream magnetron SR latch and keeps an internal copy of its Q.
// Each frame has SLOTS slots of TICKS_PER_SLOT cycles. The magnetron is on
// for the first power_q slots of every frame, for frame_rem frames.
module mag_power_ctrl #(
  parameter int TICKS_PER_SLOT = 100,
  parameter int SLOTS          = 10,
  parameter int FRAME_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               door_open,
  input  logic [3:0]         power,
  input  logic [FRAME_W-1:0] frames,
  output logic               set_o,
  output logic               reset_o,
  output logic               mag_on,
  output logic               running,
  output logic               done
);

  localparam int TW = (TICKS_PER_SLOT > 2) ? $clog2(TICKS_PER_SLOT) : 1;

  localparam logic [TW-1:0]      TICK_LAST = TW'(TICKS_PER_SLOT - 1);
  localparam logic [3:0]         SLOT_LAST = 4'(SLOTS - 1);
  localparam logic [3:0]         SLOTS_L   = 4'(SLOTS);
  localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [3:0]         slot_q, slot_d;
  logic [FRAME_W-1:0] frame_rem_q, frame_rem_d;
  logic [3:0]         power_q, power_d;
  logic               set_q, set_d;
  logic               reset_q, reset_d;
  logic               mag_q, mag_d;
  logic               running_q, running_d;
  logic               done_q, done_d;

  logic [3:0] power_eff;
  logic [3:0] slot_inc;
  logic       tick_wrap;
  logic       slot_wrap;
  logic       abort_req;
  logic       start_ok;

  // Saturate the requested power level and decode the per-cycle events.
  always_comb begin
    power_eff = (power > SLOTS_L) ? SLOTS_L : power;
    slot_inc  = slot_q + 4'd1;
    tick_wrap = (tick_q == TICK_LAST);
    slot_wrap = (slot_q == SLOT_LAST);
    abort_req = stop | door_open;
    start_ok  = start & ~door_open & (power_eff != 4'd0) & (frames != '0);
  end

  // Next-state logic: abort beats completion, which beats slot events.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    slot_d      = slot_q;
    frame_rem_d = frame_rem_q;
    power_d     = power_q;
    set_d       = 1'b0;
    reset_d     = 1'b0;
    mag_d       = mag_q;
    running_d   = running_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d     = ST_RUN;
          power_d     = power_eff;
          frame_rem_d = frames;
          tick_d      = '0;
          slot_d      = '0;
          running_d   = 1'b1;
          set_d       = 1'b1;
          mag_d       = 1'b1;
        end
      end

      ST_RUN: begin
        if (abort_req) begin
          state_d   = ST_IDLE;
          running_d = 1'b0;
          reset_d   = mag_q;
          mag_d     = 1'b0;
        end else if (!tick_wrap) begin
          tick_d = tick_q + TW'(1);
        end else begin
          tick_d = '0;
          if (slot_wrap) begin
            slot_d = '0;
            if (frame_rem_q == FRAME_ONE) begin
              // Natural end of the cook cycle.
              state_d     = ST_IDLE;
              frame_rem_d = '0;
              running_d   = 1'b0;
              done_d      = 1'b1;
              reset_d     = mag_q;
              mag_d       = 1'b0;
            end else begin
              frame_rem_d = frame_rem_q - FRAME_ONE;
              // At full power the latch is still set, so no pulse.
              if (!mag_q) begin
                set_d = 1'b1;
                mag_d = 1'b1;
              end
            end
          end else begin
            slot_d = slot_inc;
            // slot_inc never reaches SLOTS, so full power never turns off here.
            if (slot_inc == power_q) begin
              reset_d = 1'b1;
              mag_d   = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        running_d = 1'b0;
        reset_d   = 1'b1;
        mag_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset holds the latch cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      slot_q      <= '0;
      frame_rem_q <= '0;
      power_q     <= '0;
      set_q       <= 1'b0;
      reset_q     <= 1'b1;
      mag_q       <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      slot_q      <= slot_d;
      frame_rem_q <= frame_rem_d;
      power_q     <= power_d;
      set_q       <= set_d;
      reset_q     <= reset_d;
      mag_q       <= mag_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  assign set_o   = set_q;
  assign reset_o = reset_q;
  assign mag_on  = mag_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mag_power_ctrl.sv
// Bench for mag_power_ctrl: IDLE acceptance table, directed multi-cycle
// sequences with fixed expected cycle numbers, and random stimulus checked
// against a waveform-level reference model.
module tb_mag_power_ctrl;

  localparam int T  = 2;
  localparam int S  = 10;
  localparam int FW = 8;
  localparam int FL = T * S;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          door_open = 1'b0;
  logic [3:0]    power = '0;
  logic [FW-1:0] frames = '0;
  logic          set_o, reset_o, mag_on, running, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic h_set[0:255];
  logic h_rst[0:255];
  logic h_done[0:255];
  logic h_run[0:255];
  logic h_mag[0:255];

  // Reference model: magnetron should be on while the offset into the
  // current frame is below power*T; pulses are the edges of that waveform.
  bit m_run = 0;
  int m_e = 0, m_p = 0, m_nf = 0;
  bit m_mag = 0, m_set = 0, m_reset = 0, m_done = 0, m_running = 0;

  always #5 clk = ~clk;

  mag_power_ctrl #(
    .TICKS_PER_SLOT(T),
    .SLOTS(S),
    .FRAME_W(FW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .door_open(door_open),
    .power(power),
    .frames(frames),
    .set_o(set_o),
    .reset_o(reset_o),
    .mag_on(mag_on),
    .running(running),
    .done(done)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(string name, logic act, logic want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, want, $time);
    end
  endtask

  task automatic model_edge();
    int eff;
    int pos;
    bit mag_new;
    m_set = 0; m_reset = 0; m_done = 0;
    eff = (power > S) ? S : int'(power);
    if (rst) begin
      m_run = 0; m_mag = 0; m_running = 0; m_reset = 1;
    end else if (!m_run) begin
      if (start && !door_open && eff > 0 && frames != 0) begin
        m_run = 1; m_e = 0; m_p = eff; m_nf = int'(frames);
        m_set = 1; m_mag = 1; m_running = 1;
      end
    end else if (stop || door_open) begin
      m_run = 0; m_running = 0; m_reset = m_mag; m_mag = 0;
    end else begin
      m_e++;
      if (m_e == m_nf * FL) begin
        m_run = 0; m_running = 0; m_done = 1; m_reset = m_mag; m_mag = 0;
      end else begin
        pos     = m_e % FL;
        mag_new = (pos < m_p * T);
        m_set   = mag_new && !m_mag;
        m_reset = !mag_new && m_mag;
        m_mag   = mag_new;
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    if (cyc < 256) begin
      h_set[cyc] = set_o; h_rst[cyc] = reset_o; h_done[cyc] = done;
      h_run[cyc] = running; h_mag[cyc] = mag_on;
    end
    chk({tag, " set_o"},   set_o,   m_set);
    chk({tag, " reset_o"}, reset_o, m_reset);
    chk({tag, " mag_on"},  mag_on,  m_mag);
    chk({tag, " running"}, running, m_running);
    chk({tag, " done"},    done,    m_done);
  endtask

  task automatic steps(string tag, int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  function automatic logic hv(int sel, int k);
    case (sel)
      0: return h_set[k];
      1: return h_rst[k];
      2: return h_done[k];
      3: return h_run[k];
      default: return h_mag[k];
    endcase
  endfunction

  // Pulse signal must be high exactly at cycles c1/c2 (0 = unused) in 1..n.
  task automatic check_pulses(string name, int sel, int c1, int c2, int n);
    int bad = 0;
    checks++;
    for (int k = 1; k <= n; k++)
      if (bad == 0 && hv(sel, k) !== ((k == c1) || (k == c2))) bad = k;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s cycle %0d actual=%b expected=%b", name, bad, hv(sel, bad),
               (bad == c1) || (bad == c2));
    end
  endtask

  // Level signal must be high exactly over cycles lo..hi within 1..n.
  task automatic check_level(string name, int sel, int lo, int hi, int n);
    int bad = 0;
    checks++;
    for (int k = 1; k <= n; k++)
      if (bad == 0 && hv(sel, k) !== (k >= lo && k <= hi)) bad = k;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s cycle %0d actual=%b expected=%b", name, bad, hv(sel, bad),
               (bad >= lo && bad <= hi));
    end
  endtask

  // Pulse start for the accepting edge; afterwards cyc counts cycles from 1.
  task automatic begin_run(string tag, int p, int f);
    power = 4'(p); frames = FW'(f); start = 1'b1; cyc = 0;
    step(tag);
    start = 1'b0;
  endtask

  typedef struct {
    logic       start;
    logic       door;
    logic [3:0] power;
    int         frames;
    logic       accept;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'd3,  1,   1'b1};
    vecs[1] = '{1'b1, 1'b0, 4'd0,  5,   1'b0};
    vecs[2] = '{1'b1, 1'b0, 4'd5,  0,   1'b0};
    vecs[3] = '{1'b1, 1'b1, 4'd5,  5,   1'b0};
    vecs[4] = '{1'b0, 1'b0, 4'd5,  5,   1'b0};
    vecs[5] = '{1'b1, 1'b0, 4'd15, 1,   1'b1};
    vecs[6] = '{1'b1, 1'b0, 4'd1,  255, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 4'd11, 0,   1'b0};

    // Reset held three cycles, then released.
    cyc = 0;
    steps("rst", 3);
    chk("rst reset_o high", reset_o, 1'b1);
    chk("rst set_o low", set_o, 1'b0);
    chk("rst running low", running, 1'b0);
    rst = 1'b0;
    step("rst release");
    chk("rst release reset_o", reset_o, 1'b0);

    // Start acceptance from IDLE; accepted runs are cancelled with stop.
    foreach (vecs[i]) begin
      start = vecs[i].start; door_open = vecs[i].door;
      power = vecs[i].power; frames = FW'(vecs[i].frames);
      step("vec");
      chk($sformatf("vec%0d set_o", i), set_o, vecs[i].accept);
      chk($sformatf("vec%0d running", i), running, vecs[i].accept);
      start = 1'b0; door_open = 1'b0;
      if (vecs[i].accept) begin
        stop = 1'b1;
        step("vec abort");
        chk($sformatf("vec%0d abort reset_o", i), reset_o, 1'b1);
        stop = 1'b0;
      end
      step("vec idle");
    end

    // power 3, one frame.
    begin_run("p3f1", 3, 1);
    steps("p3f1", 22);
    check_pulses("p3f1 set_o", 0, 1, 0, 23);
    check_pulses("p3f1 reset_o", 1, 7, 0, 23);
    check_pulses("p3f1 done", 2, 21, 0, 23);
    check_level("p3f1 running", 3, 1, 20, 23);
    check_level("p3f1 mag_on", 4, 1, 6, 23);

    // power 12 saturates to full power, two frames.
    begin_run("p12f2", 12, 2);
    steps("p12f2", 42);
    check_pulses("p12f2 set_o", 0, 1, 0, 43);
    check_pulses("p12f2 reset_o", 1, 41, 0, 43);
    check_pulses("p12f2 done", 2, 41, 0, 43);
    check_level("p12f2 mag_on", 4, 1, 40, 43);

    // power 5, two frames.
    begin_run("p5f2", 5, 2);
    steps("p5f2", 42);
    check_pulses("p5f2 set_o", 0, 1, 21, 43);
    check_pulses("p5f2 reset_o", 1, 11, 31, 43);
    check_pulses("p5f2 done", 2, 41, 0, 43);

    // Door opens during cycle 4, then start with the door open.
    begin_run("door", 5, 3);
    steps("door", 3);
    door_open = 1'b1;
    step("door");
    start = 1'b1;
    step("door start");
    start = 1'b0;
    step("door");
    door_open = 1'b0;
    check_pulses("door set_o", 0, 1, 0, 7);
    check_pulses("door reset_o", 1, 5, 0, 7);
    check_pulses("door done", 2, 0, 0, 7);
    check_level("door running", 3, 1, 4, 7);

    // Stop during slot 7 with power 5: magnetron already off.
    begin_run("stop", 5, 2);
    steps("stop", 14);
    stop = 1'b1;
    step("stop");
    stop = 1'b0;
    steps("stop", 2);
    check_pulses("stop set_o", 0, 1, 0, 18);
    check_pulses("stop reset_o", 1, 11, 0, 18);
    check_pulses("stop done", 2, 0, 0, 18);
    check_level("stop running", 3, 1, 15, 18);
    check_level("stop mag_on", 4, 1, 10, 18);

    // Random stimulus; power/frames keep changing during RUN.
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 149) == 0);
      door_open = ($urandom_range(0, 249) == 0);
      power     = 4'($urandom_range(0, 15));
      frames    = FW'($urandom_range(0, 3));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
